// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t : scan FSM states (BLANK gap, DRIVE digit)
//   - SEG_OFF      : active-low "all segments dark" pattern
//   - HEX_SEG      : hex nibble -> active-low segment pattern (bit0=a .. bit6=g)
//   - max2()       : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Common-anode display: a 0 lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   nibble  in  4 : hex value to display
//   seg     out 7 : active-low segments, bit0=a .. bit6=g
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. A client loads a full display image (nibbles, decimal points, blank
// mask) through a valid/ready handshake into a shadow buffer; the shadow is
// promoted to the active image only at a frame boundary so the display never
// tears. Each digit slot is a BLANK gap (all anodes off) followed by DRIVE.
//
// Optional feature (compile-time macro SEG7_BRIGHTNESS_EN):
//   adds a 4-bit `brightness` input that PWM-dims segments/dp inside DRIVE.
//
// Ports:
//   clk          in  1            : clock
//   rst          in  1            : synchronous active-high reset
//   in_valid     in  1            : new image offered
//   in_ready     out 1            : shadow free; accept on in_valid && in_ready
//   in_digits    in  4*NUM_DIGITS : nibble per digit, digit i = [4i+3:4i]
//   in_dp        in  NUM_DIGITS   : 1 = decimal point lit for digit i
//   in_blank     in  NUM_DIGITS   : 1 = digit i fully dark
//   brightness   in  4            : (SEG7_BRIGHTNESS_EN only) 15 = full duty
//   anode        out NUM_DIGITS   : active-low digit enables
//   cathode      out 7            : active-low segments, bit0=a .. bit6=g
//   dp           out 1            : active-low decimal point
//   frame_tick   out 1            : one-cycle pulse as digit 0's BLANK appears
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DRIVE_CYCLES = 99000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_digits,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic [NUM_DIGITS-1:0]   in_blank,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_tick
);

    // -------------------------------------------------------------------------
    // Sizing
    // -------------------------------------------------------------------------
    localparam int CNT_MAX = max2(DRIVE_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // -------------------------------------------------------------------------
    // Scan FSM: state, slot counter, digit index
    // -------------------------------------------------------------------------
    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_end;    // last DRIVE cycle of the last digit

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        frame_end = 1'b0;

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Double-buffered image
    // -------------------------------------------------------------------------
    logic                        pending_q;
    logic                        accept;
    logic                        swap;

    logic [NUM_DIGITS-1:0][3:0]  shadow_digits_q;
    logic [NUM_DIGITS-1:0]       shadow_dp_q;
    logic [NUM_DIGITS-1:0]       shadow_blank_q;

    logic [NUM_DIGITS-1:0][3:0]  active_digits_q;
    logic [NUM_DIGITS-1:0]       active_dp_q;
    logic [NUM_DIGITS-1:0]       active_blank_q;

    assign in_ready = !pending_q;
    assign accept   = in_valid && !pending_q;
    // Only an image pending before the boundary cycle is promoted; an accept in
    // the boundary cycle itself sees pending_q low here and waits a frame.
    assign swap     = frame_end && pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (swap) begin
            pending_q <= 1'b0;
        end else if (accept) begin
            pending_q <= 1'b1;
        end
    end

    // NOTE: the shadow buffer is deliberately not reset; it is only ever read
    // while pending_q qualifies it, so its power-up contents are irrelevant.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow_digits_q <= in_digits;
            shadow_dp_q     <= in_dp;
            shadow_blank_q  <= in_blank;
        end
    end

    // The active image does reset: a fresh display must come up dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_digits_q <= '0;
            active_dp_q     <= '0;
            active_blank_q  <= '1;
        end else if (swap) begin
            active_digits_q <= shadow_digits_q;
            active_dp_q     <= shadow_dp_q;
            active_blank_q  <= shadow_blank_q;
        end
    end

    // -------------------------------------------------------------------------
    // Segment decode of the digit currently being scanned
    // -------------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;

    assign cur_nibble = active_digits_q[idx_q];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // -------------------------------------------------------------------------
    // Brightness gating
    // -------------------------------------------------------------------------
    logic seg_lit;

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_q;

    // Held at zero outside DRIVE so each DRIVE phase starts its PWM at 0.
    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_DRIVE)) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
        end
    end

    assign seg_lit = (pwm_q <= brightness);
`else
    assign seg_lit = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Output stage (registered, one cycle behind the FSM)
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] anode_d;
    logic [6:0]            cathode_d;
    logic                  dp_d;
    logic                  wrap_q;     // FSM has just wrapped to digit 0 BLANK

    always_comb begin
        anode_d   = '1;
        cathode_d = SEG_OFF;
        dp_d      = 1'b1;
        if (state_q == ST_DRIVE) begin
            // Blanked digits keep their anode asserted so every slot has the
            // same on-time and the scan period stays uniform.
            anode_d[idx_q] = 1'b0;
            if (!active_blank_q[idx_q] && seg_lit) begin
                cathode_d = cur_seg;
                dp_d      = !active_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode      <= '1;
            cathode    <= SEG_OFF;
            dp         <= 1'b1;
            wrap_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            anode      <= anode_d;
            cathode    <= cathode_d;
            dp         <= dp_d;
            // Two stages so the pulse lines up with digit 0's BLANK on the pins.
            wrap_q     <= frame_end;
            frame_tick <= wrap_q;
        end
    end

endmodule
